// File: rtl/ineq_pkg.sv
// Shared types and helpers for the inequality sweep controller.
package ineq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DONE
    } state_t;

    localparam int unsigned NUM_W_DEF  = 4;
    localparam int unsigned NUM_VALUES = 2 ** NUM_W_DEF;

    // Bit position of OUT[k] captured at NUM=n inside the flattened mask.
    function automatic int unsigned mask_idx(input int unsigned k,
                                             input int unsigned n,
                                             input int unsigned nvals = NUM_VALUES);
        return k * nvals + n;
    endfunction

endpackage

// File: rtl/ineq_settle_timer.sv
// Load/decrement settle counter with a zero flag; load wins over counting.
module ineq_settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic zero
);

    localparam logic [3:0] LOAD_VAL = 4'(SETTLE);

    logic [3:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/ineq_sweep_ctrl.sv
// Sweeps an inequality evaluator over every NUM value and records its truth table.
// Optional self-check against expected_i when INEQ_SWEEP_CHECK_EN is defined.
module ineq_sweep_ctrl
    import ineq_pkg::*;
#(
    parameter int unsigned NUM_W  = 4,
    parameter int unsigned OUT_W  = 3,
    parameter int unsigned SETTLE = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start_i,
    input  logic                          abort_i,
    output logic [NUM_W-1:0]              num_o,
    input  logic [OUT_W-1:0]              out_i,
    output logic                          busy_o,
    output logic                          done_o,
    output logic [OUT_W*(2**NUM_W)-1:0]   mask_o,
    output logic [OUT_W*(NUM_W+1)-1:0]    ones_o
`ifdef INEQ_SWEEP_CHECK_EN
    ,
    input  logic [OUT_W*(2**NUM_W)-1:0]   expected_i,
    output logic                          mismatch_o,
    output logic [NUM_W-1:0]              fail_num_o
`endif
);

    localparam int unsigned     NVALS    = 2 ** NUM_W;
    localparam logic [NUM_W-1:0] LAST_NUM = '1;

    state_t state, state_nx;
    logic   zero;
    logic   start_go;
    logic   capture;
    logic   last;
    logic   load;

    // Abort beats both a start in IDLE and a capture in WAIT.
    assign start_go = (state == IDLE) && start_i && !abort_i;
    assign capture  = (state == WAIT) && zero && !abort_i;
    assign last     = (num_o == LAST_NUM);
    assign load     = start_go || (capture && !last);

    ineq_settle_timer #(
        .SETTLE(SETTLE)
    ) u_timer (
        .clk  (clk),
        .rst_n(rst_n),
        .load (load),
        .zero (zero)
    );

    always_comb begin
        state_nx = state;
        busy_o   = 1'b0;
        done_o   = 1'b0;
        case (state)
            IDLE: begin
                if (start_go) state_nx = WAIT;
            end
            WAIT: begin
                busy_o = 1'b1;
                if (abort_i)              state_nx = IDLE;
                else if (capture && last) state_nx = DONE;
            end
            DONE: begin
                done_o   = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            num_o <= '0;
        end else begin
            state <= state_nx;
            if (start_go || ((state == WAIT) && abort_i)) begin
                num_o <= '0;
            end else if (capture && !last) begin
                num_o <= num_o + NUM_W'(1);
            end
        end
    end

    logic [OUT_W-1:0] diff;

    // One truth-table row and ones counter per evaluator output bit.
    for (genvar k = 0; k < OUT_W; k++) begin : g_bit
        logic [NVALS-1:0] row;
        logic [NUM_W:0]   cnt;
        logic [NVALS-1:0] exp_row;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                row <= '0;
                cnt <= '0;
            end else if (start_go) begin
                row <= '0;
                cnt <= '0;
            end else if (capture) begin
                row[num_o] <= out_i[k];
                cnt        <= cnt + {{NUM_W{1'b0}}, out_i[k]};
            end
        end

        assign mask_o[mask_idx(k, 0, NVALS) +: NVALS] = row;
        assign ones_o[k*(NUM_W+1) +: (NUM_W+1)]       = cnt;

`ifdef INEQ_SWEEP_CHECK_EN
        assign exp_row = expected_i[mask_idx(k, 0, NVALS) +: NVALS];
`else
        assign exp_row = row;
`endif
        assign diff[k] = exp_row[num_o] ^ out_i[k];
    end

`ifdef INEQ_SWEEP_CHECK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mismatch_o <= 1'b0;
            fail_num_o <= '0;
        end else if (start_go) begin
            mismatch_o <= 1'b0;
            fail_num_o <= '0;
        end else if (capture && (diff != '0) && !mismatch_o) begin
            mismatch_o <= 1'b1;
            fail_num_o <= num_o;
        end
    end
`else
    logic unused_diff;
    assign unused_diff = ^diff;
`endif

endmodule
